// File: rtl/conv_pkg.sv
// Shared mode encoding and code-range limits for the 4-bit code converter.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_B2G     = 2'b00,
    MODE_G2B     = 2'b01,
    MODE_BCD2XS3 = 2'b10,
    MODE_XS32BCD = 2'b11
  } mode_e;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;
  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] ERR_FILL   = 4'b0000;

endpackage

// File: rtl/code_conv_core.sv
// Combinational binary/Gray and BCD/Excess-3 conversion with invalid-code flag.
// Latency 0 (pure logic); no backpressure, result follows inputs.
module code_conv_core
  import conv_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] code_a,
  output logic [3:0] code_b,
  output logic       err
);

  always_comb begin
    code_b = ERR_FILL;
    err    = 1'b0;
    case (mode_e'(mode))
      MODE_B2G: code_b = code_a ^ (code_a >> 1);
      // Each binary bit is the XOR of all Gray bits at or above it.
      MODE_G2B: code_b = {code_a[3],
                          ^code_a[3:2],
                          ^code_a[3:1],
                          ^code_a[3:0]};
      MODE_BCD2XS3: begin
        if (code_a <= BCD_MAX) code_b = code_a + XS3_OFFSET;
        else                   err    = 1'b1;
      end
      MODE_XS32BCD: begin
        if (code_a >= XS3_MIN && code_a <= XS3_MAX) code_b = code_a - XS3_OFFSET;
        else                                        err    = 1'b1;
      end
      default: begin
        code_b = ERR_FILL;
        err    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/code_conv.sv
// Registered 4-bit code converter: one-cycle latency from sampled a*/mode to b*/err/vld.
// No backpressure: a new code is accepted and converted on every clock edge.
module code_conv
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       a1,
  input  logic       a2,
  input  logic       a3,
  input  logic       a4,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  output logic       err,
  output logic       vld
);

  logic [3:0] code_a;
  logic [3:0] next_b;
  logic       next_err;
  logic [3:0] code_b_q;

  assign code_a = {a4, a3, a2, a1};

  code_conv_core u_core (
    .mode   (mode),
    .code_a (code_a),
    .code_b (next_b),
    .err    (next_err)
  );

  // Mode and code are captured on the same edge, so a mode switch never mixes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_b_q <= 4'b0000;
      err      <= 1'b0;
      vld      <= 1'b0;
    end else begin
      code_b_q <= next_b;
      err      <= next_err;
      vld      <= 1'b1;
    end
  end

  assign {b4, b3, b2, b1} = code_b_q;

endmodule

// File: tb/tb_code_conv.sv
// Self-checking bench for code_conv: directed vector table, hand sequences, random vs model.
module tb_code_conv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] a_in;
  logic       a1, a2, a3, a4;
  logic       b1, b2, b3, b4;
  logic       err, vld;

  int checks = 0;
  int errors = 0;

  assign {a4, a3, a2, a1} = a_in;

  always #5 clk = ~clk;

  code_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .a4    (a4),
    .b1    (b1),
    .b2    (b2),
    .b3    (b3),
    .b4    (b4),
    .err   (err),
    .vld   (vld)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       err;
    logic       vld;
  } vec_t;

  vec_t vecs[20];

  // Reference: derived from code definitions, not from bit equations.
  function automatic void ref_conv(input logic [1:0] m, input logic [3:0] a,
                                   output logic [3:0] b, output logic e);
    int v;
    v = int'(a);
    b = 4'b0000;
    e = 1'b0;
    case (m)
      2'd0: b = 4'(v ^ (v / 2));
      2'd1: begin
        for (int x = 0; x < 16; x++)
          if ((x ^ (x / 2)) == v) b = 4'(x);
      end
      2'd2: if (v <= 9) b = 4'(v + 3); else e = 1'b1;
      default: if (v >= 3 && v <= 12) b = 4'(v - 3); else e = 1'b1;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] eb, input logic ee, input logic ev);
    checks++;
    if ({b4, b3, b2, b1} !== eb || err !== ee || vld !== ev) begin
      errors++;
      $display("FAIL %s: got b=%b err=%b vld=%b, want b=%b err=%b vld=%b",
               name, {b4, b3, b2, b1}, err, vld, eb, ee, ev);
    end
  endtask

  // Drive after the falling edge, let the rising edge sample, observe at the next fall.
  task automatic step(input logic r, input logic [1:0] m, input logic [3:0] a);
    rst_n = r;
    mode  = m;
    a_in  = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] eb;
    logic       ee;
    logic       r;
    logic [1:0] m;
    logic [3:0] a;

    vecs[0]  = '{1'b0, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 4'b1111, 4'b1000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 4'b0101, 4'b0111, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'b01, 4'b0111, 4'b0101, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 2'b01, 4'b1000, 4'b1111, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 2'b10, 4'b0000, 4'b0011, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 2'b10, 4'b1001, 4'b1100, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 2'b10, 4'b1010, 4'b0000, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 2'b11, 4'b0011, 4'b0000, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 2'b11, 4'b1100, 4'b1001, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 4'b0010, 4'b0000, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 2'b11, 4'b1101, 4'b0000, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 2'b10, 4'b1001, 4'b1100, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 2'b11, 4'b1001, 4'b0110, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 2'b11, 4'b1001, 4'b0000, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 2'b00, 4'b0011, 4'b0010, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 2'b10, 4'b0010, 4'b0101, 1'b0, 1'b1};

    rst_n = 1'b0;
    mode  = 2'b00;
    a_in  = 4'b1111;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst_n, vecs[i].mode, vecs[i].a);
      check($sformatf("vec%0d", i), vecs[i].b, vecs[i].err, vecs[i].vld);
    end

    // Full sweeps of the two Gray directions.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b00, 4'(i));
      ref_conv(2'b00, 4'(i), eb, ee);
      check($sformatf("b2g_sweep%0d", i), eb, ee, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'b01, 4'(i ^ (i / 2)));
      check($sformatf("g2b_round%0d", i), 4'(i), 1'b0, 1'b1);
    end

    // Mode flips between edges: output holds until the edge, then jumps straight.
    step(1'b1, 2'b10, 4'b1001);
    mode = 2'b11;
    #2;
    check("hold_before_edge", 4'b1100, 1'b0, 1'b1);
    a_in = 4'b0000;
    #1;
    check("hold_input_change", 4'b1100, 1'b0, 1'b1);
    a_in = 4'b1001;
    @(posedge clk);
    #1;
    check("switch_after_edge", 4'b0110, 1'b0, 1'b1);
    @(negedge clk);

    // Reset dominates any inputs present on the same edge.
    step(1'b0, 2'b10, 4'b1111);
    check("reset_priority", 4'b0000, 1'b0, 1'b0);
    step(1'b1, 2'b10, 4'b1111);
    check("post_reset_err", 4'b0000, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      m = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      step(r, m, a);
      if (r) ref_conv(m, a, eb, ee);
      else begin
        eb = 4'b0000;
        ee = 1'b0;
      end
      check($sformatf("rand%0d m=%0d a=%b r=%b", i, m, a, r), eb, ee, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
